// File: rtl/fetch_stage.sv
// Instruction fetch stage: 2-entry {pc, instr} buffer in front of a single-outstanding memory port.
// Optional bubble counter is built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        taken,
    input  logic [31:0] branch_target,
    input  logic        flush_fe,
    input  logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fe_valid,
    output logic [31:0] fe_instr,
    output logic [31:0] fe_pc,
    output logic [31:0] fetch_bubbles
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [1:0]  count;
    logic [31:0] pc0, pc1, instr0, instr1;

    logic        redirect, accept, push, pop;
    logic [1:0]  occ_next;
    logic [31:0] target, pc_inc;

    assign redirect = taken | flush_fe;
    assign target   = branch_target & ~32'd3;
    assign pc_inc   = fetch_pc + 32'd4;
    assign accept   = imem_req & imem_ack;
    // Responses are only kept in REQ; a DRAIN ack belongs to the abandoned path.
    assign push     = accept & (state == REQ) & ~redirect;
    assign pop      = (count != 2'd0) & ~pc_stall & ~redirect;

    always_comb begin
        occ_next = count;
        if (push && !pop)
            occ_next = count + 2'd1;
        else if (pop && !push)
            occ_next = count - 2'd1;
    end

    assign fe_valid = (count != 2'd0);
    assign fe_pc    = pc0;
    assign fe_instr = instr0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            pc0    <= 32'd0;
            pc1    <= 32'd0;
            instr0 <= 32'd0;
            instr1 <= 32'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            count <= occ_next;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        pc0    <= imem_addr;
                        instr0 <= imem_rdata;
                    end else begin
                        pc1    <= imem_addr;
                        instr1 <= imem_rdata;
                    end
                end
                2'b01: begin
                    pc0    <= pc1;
                    instr0 <= instr1;
                end
                2'b11: begin
                    // With one entry the new word goes straight to the head.
                    if (count == 2'd1) begin
                        pc0    <= imem_addr;
                        instr0 <= imem_rdata;
                    end else begin
                        pc0    <= pc1;
                        instr0 <= instr1;
                        pc1    <= imem_addr;
                        instr1 <= imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect ? target : fetch_pc;
                    fetch_pc  <= redirect ? target : fetch_pc;
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        if (imem_req && !imem_ack) begin
                            state <= DRAIN;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= target;
                        end
                    end else if (accept) begin
                        fetch_pc <= pc_inc;
                        if (occ_next < 2'd2) begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc_inc;
                        end else begin
                            imem_req <= 1'b0;
                        end
                    end else if (!imem_req && occ_next <= 2'd1) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                DRAIN: begin
                    if (redirect)
                        fetch_pc <= target;
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= 32'd0;
        else if (!fe_valid && bubble_cnt != 32'hFFFF_FFFF)
            bubble_cnt <= bubble_cnt + 32'd1;
    end

    assign fetch_bubbles = bubble_cnt;
`else
    assign fetch_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based buffer model checked every cycle plus literal checkpoints.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        taken = 1'b0, flush_fe = 1'b0, pc_stall = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        fe_valid;
    logic [31:0] fe_instr, fe_pc, fetch_bubbles;

    logic        imem_req2, fe_valid2;
    logic [31:0] imem_addr2, fe_instr2, fe_pc2, fetch_bubbles2;

    int tests = 0, fails = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .taken(taken), .branch_target(branch_target),
        .flush_fe(flush_fe), .pc_stall(pc_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fe_valid(fe_valid),
        .fe_instr(fe_instr), .fe_pc(fe_pc), .fetch_bubbles(fetch_bubbles)
    );

    // Second instance with a wrapping start address and an always-ready memory.
    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .taken(1'b0), .branch_target(32'd0),
        .flush_fe(1'b0), .pc_stall(1'b0), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_req2), .imem_rdata(imem_addr2), .fe_valid(fe_valid2),
        .fe_instr(fe_instr2), .fe_pc(fe_pc2), .fetch_bubbles(fetch_bubbles2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int mem_lat = 0;
    int ack_budget = 0;
    int wait_cnt = 0;
    logic stray_ack = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n || !imem_req) begin
            wait_cnt = 0;
            imem_ack = stray_ack;
        end else begin
            imem_ack = (wait_cnt >= mem_lat) && (ack_budget > 0);
            if (imem_ack) begin
                wait_cnt = 0;
                ack_budget--;
            end else begin
                wait_cnt++;
            end
        end
        imem_rdata = word_of(imem_addr);
    end

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] log2[$];
    logic [31:0] exp_fetch = 32'd0;
    logic [31:0] bub = 32'd0;
    logic [31:0] hold_addr = 32'd0;
    logic        drain = 1'b0, hold_pending = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) log2.delete();
        else if (imem_req2) log2.push_back(imem_addr2);
    end

    always begin
        logic        r_req, r_ack, r_redir, r_stall, acc, pop;
        logic [31:0] r_addr, r_data, r_tgt;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_instr_q.delete();
            acc_log.delete();
            exp_fetch    = 32'd0;
            bub          = 32'd0;
            drain        = 1'b0;
            hold_pending = 1'b0;
        end else begin
            r_req   = imem_req;
            r_ack   = imem_ack;
            r_addr  = imem_addr;
            r_data  = imem_rdata;
            r_redir = taken | flush_fe;
            r_tgt   = {branch_target[31:2], 2'b00};
            r_stall = pc_stall;
            if (hold_pending) begin
                check("req_held", {31'd0, r_req}, 32'd1);
                check("addr_held", r_addr, hold_addr);
            end
            hold_pending = r_req && !r_ack;
            hold_addr    = r_addr;
            if (exp_q.size() == 0 && bub != 32'hFFFF_FFFF) bub++;
            acc = r_req && r_ack;
            pop = (exp_q.size() > 0) && !r_stall && !r_redir;
            if (r_redir) begin
                exp_q.delete();
                exp_instr_q.delete();
                drain     = r_req && !r_ack;
                exp_fetch = r_tgt;
            end else if (acc && drain) begin
                drain = 1'b0;
            end else begin
                if (pop) begin
                    void'(exp_q.pop_front());
                    void'(exp_instr_q.pop_front());
                end
                if (acc) begin
                    check("fetch_addr", r_addr, exp_fetch);
                    acc_log.push_back(r_addr);
                    check("fifo_room", {31'd0, exp_q.size() < 2}, 32'd1);
                    exp_q.push_back(r_addr);
                    exp_instr_q.push_back(r_data);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
            #1;
            check("fe_valid", {31'd0, fe_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                check("fe_pc", fe_pc, exp_q[0]);
                check("fe_instr", fe_instr, exp_instr_q[0]);
            end
            check("req_when_full", {31'd0, imem_req && exp_q.size() >= 2}, 32'd0);
            check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
`ifdef FETCH_PERF_EN
            check("bubbles", fetch_bubbles, bub);
`else
            check("bubbles", fetch_bubbles, 32'd0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        taken = 1'b0;
        flush_fe = 1'b0;
        pc_stall = 1'b0;
        branch_target = 32'd0;
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input int budget);
        int n = 0;
        logic found = 1'b0;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (imem_req && imem_addr == a) found = 1'b1;
        end
        check("wait_req_addr", {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [39:0] stall_pat;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'd0, fe_valid}, 32'd0);
        check("rst_pc", fe_pc, 32'd0);
        check("rst_instr", fe_instr, 32'd0);
        check("rst_bubbles", fetch_bubbles, 32'd0);
        check("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

        // Memory acking one cycle after each request
        mem_lat = 1;
        ack_budget = 1000;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("first_valid", {31'd0, fe_valid}, 32'd1);
        check("first_pc", fe_pc, 32'd0);
        check("first_instr", fe_instr, word_of(32'd0));
        repeat (5) @(negedge clk);
        check("seq_len", {31'd0, acc_log.size() >= 3}, 32'd1);
        if (acc_log.size() >= 3) begin
            check("seq0", acc_log[0], 32'h0);
            check("seq1", acc_log[1], 32'h4);
            check("seq2", acc_log[2], 32'h8);
        end
        check("wrap_len", {31'd0, log2.size() >= 3}, 32'd1);
        if (log2.size() >= 3) begin
            check("wrap0", log2[0], 32'hFFFF_FFF8);
            check("wrap1", log2[1], 32'hFFFF_FFFC);
            check("wrap2", log2[2], 32'h0000_0000);
        end

        // Stall with an always-acking memory fills the buffer
        do_reset();
        mem_lat = 0;
        ack_budget = 1000;
        pc_stall = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("stall_req", {31'd0, imem_req}, 32'd0);
        check("stall_valid", {31'd0, fe_valid}, 32'd1);
        check("stall_pc", fe_pc, 32'd0);
        pc_stall = 1'b0;
        @(negedge clk);
        check("unstall_pc", fe_pc, 32'd4);
        check("unstall_req", {31'd0, imem_req}, 32'd1);
        check("unstall_addr", imem_addr, 32'd8);
        repeat (8) @(negedge clk);

        // Redirect while the request to 8 is unacked
        do_reset();
        mem_lat = 0;
        ack_budget = 2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("pend_req", {31'd0, imem_req}, 32'd1);
        check("pend_addr", imem_addr, 32'd8);
        taken = 1'b1;
        branch_target = 32'h0000_0102;
        @(negedge clk);
        taken = 1'b0;
        check("drain_req", {31'd0, imem_req}, 32'd1);
        check("drain_addr", imem_addr, 32'd8);
        check("drain_valid", {31'd0, fe_valid}, 32'd0);
        ack_budget = 1;
        @(negedge clk);
        check("drain_drop", {31'd0, imem_req}, 32'd0);
        ack_budget = 100;
        @(negedge clk);
        check("tgt_req", {31'd0, imem_req}, 32'd1);
        check("tgt_addr", imem_addr, 32'h0000_0100);
        @(negedge clk);
        check("tgt_pc", fe_pc, 32'h0000_0100);
        check("tgt_instr", fe_instr, word_of(32'h0000_0100));
        repeat (4) @(negedge clk);

        // A second redirect during the drain replaces the target
        do_reset();
        mem_lat = 0;
        ack_budget = 2;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        taken = 1'b1;
        branch_target = 32'h0000_0102;
        @(negedge clk);
        taken = 1'b0;
        flush_fe = 1'b1;
        branch_target = 32'h0000_0204;
        @(negedge clk);
        flush_fe = 1'b0;
        ack_budget = 1;
        wait_req_addr(32'h0000_0204, 8);
        ack_budget = 100;
        repeat (4) @(negedge clk);

        // Redirect coinciding with an ack under stall
        do_reset();
        mem_lat = 0;
        ack_budget = 1000;
        pc_stall = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        taken = 1'b1;
        flush_fe = 1'b1;
        branch_target = 32'h0000_0040;
        @(negedge clk);
        taken = 1'b0;
        flush_fe = 1'b0;
        check("coinc_valid", {31'd0, fe_valid}, 32'd0);
        check("coinc_req", {31'd0, imem_req}, 32'd1);
        check("coinc_addr", imem_addr, 32'h0000_0040);
        @(negedge clk);
        check("coinc_pc", fe_pc, 32'h0000_0040);
        pc_stall = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-request, stray ack in IDLE, then ten ack-free cycles
        ack_budget = 0;
        @(negedge clk);
        do_reset();
        stray_ack = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("idle_ack_req", {31'd0, imem_req}, 32'd1);
        check("idle_ack_addr", imem_addr, 32'd0);
        check("idle_ack_valid", {31'd0, fe_valid}, 32'd0);
        repeat (9) @(negedge clk);
`ifdef FETCH_PERF_EN
        check("bubbles_10", fetch_bubbles, 32'd10);
`else
        check("bubbles_10", fetch_bubbles, 32'd0);
`endif

        // Mixed stall pattern with a flush and a branch
        do_reset();
        mem_lat = 1;
        ack_budget = 1000;
        stall_pat = 40'h53_C81E_6A4B;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            pc_stall = stall_pat[c];
            flush_fe = (c == 17);
            taken = (c == 29);
            branch_target = (c == 29) ? 32'h1234_567B : 32'h0000_0010;
            mem_lat = (c < 20) ? 1 : 0;
        end
        pc_stall = 1'b0;
        taken = 1'b0;
        flush_fe = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
